// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage (ALU + shifter + NZCV flag register) followed by
// the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   stall, flush            hold / squash the EX/MEM register and flags
//   data_a_ex, data_b_ex    operands from RF/EX
//   shamt_ex                shift amount (0..63)
//   aluOrShift_ex           0 = ALU result, 1 = shifter result
//   aluControl_ex           ALU op, or shift direction in bit 0 when shifting
//   set_flags_ex            instruction updates NZCV
//   Mem*/RegWrite_ex        memory / writeback control
//   reg_write_addr_ex       destination register
//   reg_b_out_stur_ex       store data
//   ex_result, ex_zero      combinational EX result and zero test (forwarding, CBZ)
//   *_m                     registered EX/MEM outputs
//   flags                   {N,Z,C,V}
//
// Optional build macro: FLAG_BYPASS_EN -- when defined, `flags` shows the newly
// computed NZCV in the same cycle as a qualifying flag update.

module ex_mem_stage #(
  parameter int unsigned DATA_W    = 64,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_a_ex,
  input  logic [DATA_W-1:0] data_b_ex,
  input  logic [5:0]        shamt_ex,
  input  logic              aluOrShift_ex,
  input  logic [2:0]        aluControl_ex,
  input  logic              set_flags_ex,
  input  logic              MemRead_ex,
  input  logic              MemWrite_ex,
  input  logic              MemtoReg_ex,
  input  logic              RegWrite_ex,
  input  logic [4:0]        reg_write_addr_ex,
  input  logic [DATA_W-1:0] reg_b_out_stur_ex,
  output logic [DATA_W-1:0] ex_result,
  output logic              ex_zero,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [DATA_W-1:0] store_data_m,
  output logic              MemRead_m,
  output logic              MemWrite_m,
  output logic              MemtoReg_m,
  output logic              RegWrite_m,
  output logic [4:0]        reg_write_addr_m,
  output logic [3:0]        flags
);

  localparam int unsigned MSB = DATA_W - 1;

  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] shift_res;
  logic              flag_c;
  logic              flag_v;
  logic [3:0]        new_flags;
  logic [3:0]        flag_q;
  logic              flag_upd;

  // Shared adder: subtraction is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    is_sub   = (aluControl_ex == 3'b011);
    b_op     = is_sub ? ~data_b_ex : data_b_ex;
    add_full = {1'b0, data_a_ex} + {1'b0, b_op} + (DATA_W+1)'(is_sub);
    add_res  = add_full[DATA_W-1:0];
  end

  // ALU operation select; 001 and 111 are unused encodings and yield zero.
  always_comb begin
    alu_res = '0;
    case (aluControl_ex)
      3'b000:  alu_res = data_b_ex;
      3'b010:  alu_res = add_res;
      3'b011:  alu_res = add_res;
      3'b100:  alu_res = data_a_ex & data_b_ex;
      3'b101:  alu_res = data_a_ex | data_b_ex;
      3'b110:  alu_res = data_a_ex ^ data_b_ex;
      default: alu_res = '0;
    endcase
  end

  // Logical shifter on operand A.
  always_comb begin
    shift_res = aluControl_ex[0] ? (data_a_ex >> shamt_ex) : (data_a_ex << shamt_ex);
  end

  assign ex_result = aluOrShift_ex ? shift_res : alu_res;
  assign ex_zero   = (ex_result == '0);

  // C and V only carry meaning for add/sub; V uses the adder's actual B input.
  always_comb begin
    is_arith  = !aluOrShift_ex && ((aluControl_ex == 3'b010) || is_sub);
    flag_c    = is_arith && add_full[DATA_W];
    flag_v    = is_arith && (data_a_ex[MSB] == b_op[MSB]) && (add_res[MSB] != data_a_ex[MSB]);
    new_flags = {ex_result[MSB], ex_zero, flag_c, flag_v};
    flag_upd  = set_flags_ex && !stall && !flush;
  end

  // NZCV register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= FLAGS_RST;
    end else if (flag_upd) begin
      flag_q <= new_flags;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags = flag_upd ? new_flags : flag_q;
`else
  assign flags = flag_q;
`endif

  // EX/MEM register: flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_m     <= '0;
      store_data_m     <= '0;
      MemRead_m        <= 1'b0;
      MemWrite_m       <= 1'b0;
      MemtoReg_m       <= 1'b0;
      RegWrite_m       <= 1'b0;
      reg_write_addr_m <= '0;
    end else if (flush) begin
      alu_result_m     <= '0;
      store_data_m     <= '0;
      MemRead_m        <= 1'b0;
      MemWrite_m       <= 1'b0;
      MemtoReg_m       <= 1'b0;
      RegWrite_m       <= 1'b0;
      reg_write_addr_m <= '0;
    end else if (!stall) begin
      alu_result_m     <= ex_result;
      store_data_m     <= reg_b_out_stur_ex;
      MemRead_m        <= MemRead_ex;
      MemWrite_m       <= MemWrite_ex;
      MemtoReg_m       <= MemtoReg_ex;
      RegWrite_m       <= RegWrite_ex;
      reg_write_addr_m <= reg_write_addr_ex;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a table of hand-computed vectors plus short
// sequences for async reset, stall hold and flush/stall priority.

module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic [63:0] data_a_ex, data_b_ex, reg_b_out_stur_ex;
  logic [5:0]  shamt_ex;
  logic        aluOrShift_ex;
  logic [2:0]  aluControl_ex;
  logic        set_flags_ex;
  logic        MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex;
  logic [4:0]  reg_write_addr_ex;
  logic [63:0] ex_result, alu_result_m, store_data_m;
  logic        ex_zero;
  logic        MemRead_m, MemWrite_m, MemtoReg_m, RegWrite_m;
  logic [4:0]  reg_write_addr_m;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_bad = 0;

  ex_mem_stage #(.DATA_W(64), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .data_a_ex(data_a_ex), .data_b_ex(data_b_ex), .shamt_ex(shamt_ex),
    .aluOrShift_ex(aluOrShift_ex), .aluControl_ex(aluControl_ex),
    .set_flags_ex(set_flags_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
    .reg_write_addr_ex(reg_write_addr_ex), .reg_b_out_stur_ex(reg_b_out_stur_ex),
    .ex_result(ex_result), .ex_zero(ex_zero),
    .alu_result_m(alu_result_m), .store_data_m(store_data_m),
    .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m),
    .MemtoReg_m(MemtoReg_m), .RegWrite_m(RegWrite_m),
    .reg_write_addr_m(reg_write_addr_m), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a, b;
    logic [5:0]  sh;
    logic        aos;
    logic [2:0]  op;
    logic        sf;
    logic [3:0]  ctl;   // {MemRead, MemWrite, MemtoReg, RegWrite}
    logic [4:0]  rd;
    logic [63:0] st;
    logic [63:0] res;   // expected result
    logic [3:0]  fl;    // expected flags after the edge
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    data_a_ex         = v.a;
    data_b_ex         = v.b;
    shamt_ex          = v.sh;
    aluOrShift_ex     = v.aos;
    aluControl_ex     = v.op;
    set_flags_ex      = v.sf;
    {MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex} = v.ctl;
    reg_write_addr_ex = v.rd;
    reg_b_out_stur_ex = v.st;
  endtask

  task automatic chk_m(input string nm, input logic [63:0] res, input logic [63:0] st,
                       input logic [3:0] ctl, input logic [4:0] rd);
    chk({nm, ".res"}, alu_result_m, res);
    chk({nm, ".st"},  store_data_m, st);
    chk({nm, ".ctl"}, 64'({MemRead_m, MemWrite_m, MemtoReg_m, RegWrite_m}), 64'(ctl));
    chk({nm, ".rd"},  64'(reg_write_addr_m), 64'(rd));
  endtask

  function automatic vec_t mk(string nm, logic [63:0] a, logic [63:0] b, logic [5:0] sh,
                              logic aos, logic [2:0] op, logic sf, logic [3:0] ctl,
                              logic [4:0] rd, logic [63:0] st, logic [63:0] res,
                              logic [3:0] fl);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.sh = sh; v.aos = aos; v.op = op; v.sf = sf;
    v.ctl = ctl; v.rd = rd; v.st = st; v.res = res; v.fl = fl;
    return v;
  endfunction

  initial begin
    logic [3:0] prev_fl;
    logic [3:0] pre_exp;
    vec_t       v;

    // name a b sh aos op sf ctl rd st | res flags
    vt.push_back(mk("adds_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, 3'b010, 1'b1, 4'b0001, 5'd1, 64'h11, 64'h8000_0000_0000_0000, 4'b1001));
    vt.push_back(mk("subs_eq",  64'd5, 64'd5, 6'd0, 1'b0, 3'b011, 1'b1, 4'b0001, 5'd2, 64'h22, 64'd0, 4'b0110));
    vt.push_back(mk("add_nof",  64'd3, 64'd4, 6'd0, 1'b0, 3'b010, 1'b0, 4'b0001, 5'd3, 64'h33, 64'd7, 4'b0110));
    vt.push_back(mk("lsl63",    64'd1, 64'd0, 6'd63, 1'b1, 3'b000, 1'b0, 4'b0001, 5'd4, 64'h44, 64'h8000_0000_0000_0000, 4'b0110));
    vt.push_back(mk("lsr63",    64'h8000_0000_0000_0000, 64'd0, 6'd63, 1'b1, 3'b001, 1'b0, 4'b0001, 5'd5, 64'h55, 64'd1, 4'b0110));
    vt.push_back(mk("lsl0",     64'h1234, 64'd0, 6'd0, 1'b1, 3'b000, 1'b0, 4'b1011, 5'd6, 64'h66, 64'h1234, 4'b0110));
    vt.push_back(mk("lsr0",     64'hDEAD, 64'd0, 6'd0, 1'b1, 3'b001, 1'b0, 4'b0100, 5'd7, 64'h77, 64'hDEAD, 4'b0110));
    vt.push_back(mk("lsl4",     64'h0F, 64'd0, 6'd4, 1'b1, 3'b110, 1'b0, 4'b0001, 5'd8, 64'h88, 64'hF0, 4'b0110));
    vt.push_back(mk("and",      64'hF0F0, 64'h0FF0, 6'd0, 1'b0, 3'b100, 1'b0, 4'b0001, 5'd9, 64'h99, 64'h00F0, 4'b0110));
    vt.push_back(mk("or",       64'hF000, 64'h000F, 6'd0, 1'b0, 3'b101, 1'b0, 4'b0001, 5'd10, 64'hAA, 64'hF00F, 4'b0110));
    vt.push_back(mk("xor",      64'hFF, 64'h0F, 6'd0, 1'b0, 3'b110, 1'b0, 4'b0001, 5'd11, 64'hBB, 64'hF0, 4'b0110));
    vt.push_back(mk("passb",    64'd1, 64'h99, 6'd0, 1'b0, 3'b000, 1'b0, 4'b0001, 5'd12, 64'hCC, 64'h99, 4'b0110));
    vt.push_back(mk("op001",    64'd9, 64'd9, 6'd0, 1'b0, 3'b001, 1'b0, 4'b0001, 5'd13, 64'hDD, 64'd0, 4'b0110));
    vt.push_back(mk("op111",    64'd9, 64'd9, 6'd0, 1'b0, 3'b111, 1'b0, 4'b0001, 5'd14, 64'hEE, 64'd0, 4'b0110));
    vt.push_back(mk("subs_neg", 64'd3, 64'd5, 6'd0, 1'b0, 3'b011, 1'b1, 4'b0001, 5'd15, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000));
    vt.push_back(mk("adds_wrap",64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, 3'b010, 1'b1, 4'b0001, 5'd16, 64'h2, 64'd0, 4'b0110));
    vt.push_back(mk("subs_ovf", 64'h8000_0000_0000_0000, 64'd1, 6'd0, 1'b0, 3'b011, 1'b1, 4'b0001, 5'd17, 64'h3, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011));
    vt.push_back(mk("ands",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0, 3'b100, 1'b1, 4'b0001, 5'd18, 64'h4, 64'h8000_0000_0000_0000, 4'b1000));

    // Reset state
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(mk("idle", 64'd0, 64'd0, 6'd0, 1'b0, 3'b000, 1'b0, 4'b0000, 5'd0, 64'd0, 64'd0, 4'd0));
    repeat (2) @(posedge clk);
    #1;
    chk_m("rst", 64'd0, 64'd0, 4'b0000, 5'd0);
    chk("rst.flags", 64'(flags), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    prev_fl = 4'b0000;

    // Table
    foreach (vt[i]) begin
      v = vt[i];
      @(negedge clk);
      drive(v);
      #1;
      chk({v.name, ".ex_result"}, ex_result, v.res);
      chk({v.name, ".ex_zero"}, 64'(ex_zero), 64'(v.res == 64'd0));
`ifdef FLAG_BYPASS_EN
      pre_exp = v.sf ? v.fl : prev_fl;
`else
      pre_exp = prev_fl;
`endif
      chk({v.name, ".flags_pre"}, 64'(flags), 64'(pre_exp));
      @(posedge clk);
      #1;
      chk_m(v.name, v.res, v.st, v.ctl, v.rd);
      chk({v.name, ".flags"}, 64'(flags), 64'(v.fl));
      prev_fl = v.fl;
    end

    // Async reset mid-run with alu_result_m = 0x55, flags currently 1000
    @(negedge clk);
    drive(mk("p55", 64'd0, 64'h55, 6'd0, 1'b0, 3'b000, 1'b0, 4'b1111, 5'd21, 64'h5A, 64'h55, 4'b1000));
    @(posedge clk); #1;
    chk_m("pre_rst", 64'h55, 64'h5A, 4'b1111, 5'd21);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk_m("async_rst", 64'd0, 64'd0, 4'b0000, 5'd0);
    chk("async_rst.flags", 64'(flags), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    prev_fl = 4'b0000;

    // Stall hold for two cycles, then release loads the new store data
    drive(mk("stur", 64'd8, 64'h40, 6'd0, 1'b0, 3'b010, 1'b0, 4'b0100, 5'd7, 64'hAAAA, 64'h48, 4'b0000));
    @(posedge clk); #1;
    chk_m("stur", 64'h48, 64'hAAAA, 4'b0100, 5'd7);
    @(negedge clk);
    drive(mk("stur2", 64'd1, 64'd2, 6'd0, 1'b0, 3'b010, 1'b1, 4'b0101, 5'd9, 64'hBBBB, 64'd3, 4'b0000));
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk_m("stall_hold", 64'h48, 64'hAAAA, 4'b0100, 5'd7);
      chk("stall_hold.flags", 64'(flags), 64'h0);
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    chk_m("stall_rel", 64'd3, 64'hBBBB, 4'b0101, 5'd9);
    chk("stall_rel.flags", 64'(flags), 64'h0);

    // Set flags to a known nonzero value (ADDS overflow -> 1001)
    @(negedge clk);
    drive(vt[0]);
    @(posedge clk); #1;
    chk("setup.flags", 64'(flags), 64'h9);

    // SUBS with flush and stall together: bubble wins, flags unchanged
    @(negedge clk);
    drive(mk("subs_fs", 64'd5, 64'd5, 6'd0, 1'b0, 3'b011, 1'b1, 4'b0101, 5'd3, 64'h77, 64'd0, 4'b1001));
    flush = 1'b1; stall = 1'b1;
    #1;
    chk("flush_stall.flags_pre", 64'(flags), 64'h9);
    chk("flush_stall.ex_zero", 64'(ex_zero), 64'd1);
    @(posedge clk); #1;
    chk_m("flush_stall", 64'd0, 64'd0, 4'b0000, 5'd0);
    chk("flush_stall.flags", 64'(flags), 64'h9);

    // Stall alone on a flag-setting SUBS: flags must not update
    @(negedge clk);
    flush = 1'b0; stall = 1'b1;
    #1;
    chk("stall_sf.flags_pre", 64'(flags), 64'h9);
    @(posedge clk); #1;
    chk("stall_sf.flags", 64'(flags), 64'h9);
    chk_m("stall_sf", 64'd0, 64'd0, 4'b0000, 5'd0);

    // Released: SUBS 5-5 updates flags to 0110
    @(negedge clk);
    stall = 1'b0;
    #1;
`ifdef FLAG_BYPASS_EN
    chk("subs_rel.flags_pre", 64'(flags), 64'h6);
`else
    chk("subs_rel.flags_pre", 64'(flags), 64'h9);
`endif
    @(posedge clk); #1;
    chk("subs_rel.flags", 64'(flags), 64'h6);
    chk_m("subs_rel", 64'd0, 64'h77, 4'b0101, 5'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
